// File: rtl/otf_quotient_converter.sv
// On-the-fly conversion of an MSB-first signed-digit quotient stream into two's complement.
// Q and QM (= Q - 1) are kept side by side so each digit only shifts/selects, never carries.
module otf_quotient_converter #(
  parameter int unrolling  = 64,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 asyn_reset,
  input  logic                 enable,
  input  logic                 start,
  input  logic                 q_plus,
  input  logic                 q_minus,
  input  logic                 digit_valid,
  output logic                 digit_ready,
  output logic [unrolling:0]   quot,
  output logic                 quot_valid,
  input  logic                 quot_ack,
  output logic                 quot_zero
);

  localparam int W = unrolling + 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] LAST_CNT = ADDR_WIDTH'(unrolling - 1);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [W-1:0]          q_q, q_d;
  logic [W-1:0]          qm_q, qm_d;
  logic [W-1:0]          quot_q, quot_d;
  logic                  quot_zero_q, quot_zero_d;

  logic                  dig_pos, dig_neg;
  logic [W-1:0]          q_shift, qm_shift;

  // 11 decodes as zero: both bits set cancel each other
  assign dig_pos = q_plus & ~q_minus;
  assign dig_neg = q_minus & ~q_plus;

  always_comb begin
    q_shift  = (q_q << 1) | W'(1);
    qm_shift = q_q << 1;
    if (dig_neg) begin
      q_shift  = (qm_q << 1) | W'(1);
      qm_shift = qm_q << 1;
    end else if (!dig_pos) begin
      q_shift  = q_q << 1;
      qm_shift = (qm_q << 1) | W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    q_d         = q_q;
    qm_d        = qm_q;
    quot_d      = quot_q;
    quot_zero_d = quot_zero_q;
    if (enable) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = CONVERT;
            cnt_d   = '0;
            q_d     = '0;
            qm_d    = '1;
          end
        end
        CONVERT: begin
          // start wins over a same-cycle digit, which is simply dropped
          if (start) begin
            cnt_d = '0;
            q_d   = '0;
            qm_d  = '1;
          end else if (digit_valid) begin
            q_d   = q_shift;
            qm_d  = qm_shift;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
              state_d     = DONE;
              quot_d      = q_shift;
              quot_zero_d = (q_shift == '0);
            end
          end
        end
        DONE: begin
          if (start) begin
            state_d = CONVERT;
            cnt_d   = '0;
            q_d     = '0;
            qm_d    = '1;
          end else if (quot_ack) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge asyn_reset) begin
    if (!asyn_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      q_q         <= '0;
      qm_q        <= '1;
      quot_q      <= '0;
      quot_zero_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      q_q         <= q_d;
      qm_q        <= qm_d;
      quot_q      <= quot_d;
      quot_zero_q <= quot_zero_d;
    end
  end

  assign digit_ready = (state_q == CONVERT);
  assign quot_valid  = (state_q == DONE);
  assign quot        = quot_q;
  assign quot_zero   = quot_zero_q;

endmodule
